// File: rtl/npu_arb_pkg.sv
// Package npu_arb_pkg
//   Shared types and constants for the NPU arbiters.
//   - arb_state_t : burst arbiter state encoding
//   - WDOG_LIMIT  : idle cycles tolerated on the SDRAM side before a burst is
//                   abandoned (only used when ARB_WATCHDOG_EN is defined)
//   - idx_width() : width of an index into n requesters, never less than 1
package npu_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, STREAM, DONE} arb_state_t;

  localparam int WDOG_LIMIT = 4096;

  // clog2 that still yields a usable 1-bit index when n is 1 or 2
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Module rr_pick
//   Combinational round-robin picker. The search starts at the requester
//   after ptr and wraps, so the previous winner gets lowest priority.
//   Ports:
//     req    in  N   request vector
//     ptr    in  IW  index of the previous winner
//     onehot out N   one-hot winner (all zero when nothing requests)
//     idx    out IW  binary winner index (zero when nothing requests)
//     any    out 1   at least one request present
module rr_pick
  import npu_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  int             start;
  int             offset;
  int             pick;
  logic           found;

  // Rotate so the search start sits at bit 0, priority-encode, rotate back.
  always_comb begin
    doubled = {req, req};
    start   = (int'(ptr) + 1) % N;
    rotated = N'(doubled >> start);
    offset  = 0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rotated[i] && !found) begin
        offset = i;
        found  = 1'b1;
      end
    end
    pick   = (start + offset) % N;
    any    = found;
    idx    = found ? IW'(pick) : '0;
    onehot = found ? (N'(1) << pick) : '0;
  end

endmodule

// File: rtl/eu_sdram_rd_arbiter.sv
// Module eu_sdram_rd_arbiter
//   Round-robin arbiter sharing one SDRAM read-burst port among N_REQ
//   execution-unit fetch engines. A grant is held for a whole burst and each
//   beat is steered to the owning requester only.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     s_req/s_addr/s_len  per-requester request, start address, beat count
//     s_gnt               one-hot 1-cycle grant pulse
//     s_rd_valid/_data    one-hot beat strobe to owner, shared data bus
//     s_done              one-hot 1-cycle pulse after the owner's last beat
//     m_rd_req/_addr/_len burst request to SDRAM (held until m_rd_ack)
//     m_rd_ack            SDRAM accepted the burst
//     m_rd_valid/_data    beats from SDRAM
//     busy                arbiter not idle
//     err                 sticky: stray beat outside a burst, or watchdog abort
//   Configuration:
//     ARB_WATCHDOG_EN     when defined, a burst that sees no ack/beat for
//                         WDOG_LIMIT cycles is abandoned with s_done and err.
module eu_sdram_rd_arbiter
  import npu_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int LEN_W  = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        s_req,
  input  logic [N_REQ*ADDR_W-1:0] s_addr,
  input  logic [N_REQ*LEN_W-1:0]  s_len,
  output logic [N_REQ-1:0]        s_gnt,
  output logic [N_REQ-1:0]        s_rd_valid,
  output logic [DATA_W-1:0]       s_rd_data,
  output logic [N_REQ-1:0]        s_done,
  output logic                    m_rd_req,
  output logic [ADDR_W-1:0]       m_rd_addr,
  output logic [LEN_W-1:0]        m_rd_len,
  input  logic                    m_rd_ack,
  input  logic                    m_rd_valid,
  input  logic [DATA_W-1:0]       m_rd_data,
  output logic                    busy,
  output logic                    err
);

  localparam int IW = idx_width(N_REQ);

  arb_state_t        state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     owner;
  logic [LEN_W-1:0]  cnt;
  logic              mask_owner;
  logic [N_REQ-1:0]  req_eff;
  logic [N_REQ-1:0]  pick_onehot;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [N_REQ-1:0]  owner_onehot;
  logic              beat_ok;
`ifdef ARB_WATCHDOG_EN
  logic [15:0]       wdog_cnt;
`endif

  // The previous owner may still hold s_req in the idle cycle right after
  // its s_done; ignore it there so it is not mistaken for a new request.
  always_comb begin
    req_eff = s_req;
    if (mask_owner) req_eff[owner] = 1'b0;
  end

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (req_eff),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    sel_addr = s_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    sel_len  = s_len[int'(pick_idx)*LEN_W +: LEN_W];
  end

  // Beats pass straight through to the owner; nothing leaks outside STREAM.
  assign owner_onehot = N_REQ'(1) << owner;
  assign beat_ok      = (state == STREAM) && m_rd_valid;
  assign s_rd_valid   = beat_ok ? owner_onehot : '0;
  assign s_rd_data    = beat_ok ? m_rd_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= IW'(N_REQ - 1);
      owner      <= '0;
      cnt        <= '0;
      mask_owner <= 1'b0;
      s_gnt      <= '0;
      s_done     <= '0;
      m_rd_req   <= 1'b0;
      m_rd_addr  <= '0;
      m_rd_len   <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
`ifdef ARB_WATCHDOG_EN
      wdog_cnt   <= '0;
`endif
    end else begin
      s_gnt  <= '0;
      s_done <= '0;

      // Any beat outside STREAM is dropped, including one arriving with ack.
      if (m_rd_valid && (state != STREAM)) err <= 1'b1;

      case (state)
        IDLE: begin
          mask_owner <= 1'b0;
          if (pick_any) begin
            s_gnt     <= pick_onehot;
            ptr       <= pick_idx;
            owner     <= pick_idx;
            m_rd_addr <= sel_addr;
            m_rd_len  <= sel_len;
            cnt       <= '0;
            busy      <= 1'b1;
            if (sel_len != '0) begin
              state    <= ISSUE;
              m_rd_req <= 1'b1;
            end else begin
              // Zero-length request completes without touching SDRAM.
              state  <= DONE;
              s_done <= pick_onehot;
            end
          end
        end
        ISSUE: begin
          if (m_rd_ack) begin
            m_rd_req <= 1'b0;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (m_rd_valid) begin
            if (cnt == m_rd_len - LEN_W'(1)) begin
              cnt    <= '0;
              state  <= DONE;
              s_done <= owner_onehot;
            end else begin
              cnt <= cnt + LEN_W'(1);
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          mask_owner <= 1'b1;
        end
        default: state <= IDLE;
      endcase

`ifdef ARB_WATCHDOG_EN
      // Abandon a burst the SDRAM has gone silent on; overrides the case above.
      if ((state == ISSUE) || (state == STREAM)) begin
        if (m_rd_ack || m_rd_valid) begin
          wdog_cnt <= '0;
        end else if (wdog_cnt == 16'(WDOG_LIMIT - 1)) begin
          wdog_cnt <= '0;
          cnt      <= '0;
          m_rd_req <= 1'b0;
          err      <= 1'b1;
          s_done   <= owner_onehot;
          state    <= DONE;
        end else begin
          wdog_cnt <= wdog_cnt + 16'd1;
        end
      end else begin
        wdog_cnt <= '0;
      end
`endif
    end
  end

endmodule
